// File: rtl/data_mem_bus_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_bus_responder_if
// Data-memory bus between the core (master) and a memory responder (slave).
//   busReq    master->slave  request valid, held until busReady
//   busWe     master->slave  1 = store, 0 = load
//   busAddr   master->slave  byte address
//   busFunct3 master->slave  access size/sign (instr[14:12])
//   busWData  master->slave  right-aligned store data
//   busRData  slave->master  load result, valid while busReady=1
//   busReady  slave->master  one-cycle completion pulse
//   busErr    slave->master  qualifies busReady: access rejected
// ----------------------------------------------------------------------------
interface data_mem_bus_responder_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [2:0]  busFunct3;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        busReady;
  logic        busErr;

  modport master (
    output busReq, busWe, busAddr, busFunct3, busWData,
    input  busRData, busReady, busErr
  );

  modport slave (
    input  busReq, busWe, busAddr, busFunct3, busWData,
    output busRData, busReady, busErr
  );
endinterface

// File: rtl/data_mem_bus_responder.sv
// ----------------------------------------------------------------------------
// data_mem_bus_responder
// Word-organised RAM with byte lanes that answers loads and stores on the
// data-memory bus after a fixed number of wait states.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (RAM contents are kept)
//   bus      slave side of data_mem_bus_responder_if
// Flow: IDLE captures a request, WAIT burns WAIT_STATES cycles, RESP drives a
// one-cycle busReady with busErr/busRData. Stores write the RAM on the edge
// that enters RESP; loads register their result on that same edge.
// ----------------------------------------------------------------------------
module data_mem_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  data_mem_bus_responder_if.slave        bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 32'd0) ? (WAIT_STATES - 32'd1) : 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Selects the addressed byte/half and extends it according to funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Any reason to reject an access: out of range, misaligned or bad funct3.
  function automatic logic access_error(input logic        we,
                                        input logic [1:0]  lane,
                                        input logic [2:0]  f3,
                                        input logic [31:0] off);
    logic range_e;
    logic mis_e;
    logic f3_e;
    range_e = (off >= SPAN);
    mis_e   = ((f3[1:0] == 2'b01) && lane[0]) ||
              ((f3[1:0] == 2'b10) && (lane != 2'b00));
    f3_e    = we ? (f3[2] || (f3[1:0] == 2'b11))
                 : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    return range_e | mis_e | f3_e;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_we_q, cap_we_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [2:0]  cap_f3_q, cap_f3_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] ram_q [DEPTH];

  logic          capture_s;
  logic          enter_resp_s;
  logic          cur_we_s;
  logic [31:0]   cur_addr_s;
  logic [2:0]    cur_f3_s;
  logic [31:0]   cur_wdata_s;
  logic [31:0]   off_s;
  logic [AW-1:0] word_idx_s;
  logic [1:0]    lane_s;
  logic          err_s;
  logic          wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wlanes_s;

  // With zero wait states RESP is entered on the capture edge itself, so the
  // decode must look at the live bus fields while still in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we_s    = bus.busWe;
      cur_addr_s  = bus.busAddr;
      cur_f3_s    = bus.busFunct3;
      cur_wdata_s = bus.busWData;
    end else begin
      cur_we_s    = cap_we_q;
      cur_addr_s  = cap_addr_q;
      cur_f3_s    = cap_f3_q;
      cur_wdata_s = cap_wdata_q;
    end
  end

  assign off_s      = cur_addr_s - BASE_ADDR;
  assign word_idx_s = off_s[AW+1:2];
  assign lane_s     = cur_addr_s[1:0];
  assign err_s      = access_error(cur_we_s, lane_s, cur_f3_s, off_s);
  assign wr_en_s    = enter_resp_s & cur_we_s & ~err_s & reset_n;

  // Next-state and wait counter sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture_s    = 1'b0;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.busReq) begin
          capture_s = 1'b1;
          if (WAIT_STATES > 32'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture plus the response registers loaded on entry to RESP.
  always_comb begin
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_f3_d    = cap_f3_q;
    cap_wdata_d = cap_wdata_q;
    ready_d     = enter_resp_s;
    err_d       = 1'b0;
    rdata_d     = 32'h0000_0000;
    if (capture_s) begin
      cap_we_d    = bus.busWe;
      cap_addr_d  = bus.busAddr;
      cap_f3_d    = bus.busFunct3;
      cap_wdata_d = bus.busWData;
    end else begin
      cap_we_d = cap_we_q;
    end
    if (enter_resp_s) begin
      err_d = err_s;
      if (!err_s && !cur_we_s) begin
        rdata_d = load_extend(ram_q[word_idx_s], lane_s, cur_f3_s);
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Byte-enable and lane-replicated write data for SB/SH/SW.
  always_comb begin
    be_s     = 4'b0000;
    wlanes_s = 32'h0000_0000;
    case (cur_f3_s[1:0])
      2'b00: begin
        be_s     = 4'b0001 << lane_s;
        wlanes_s = {4{cur_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s     = lane_s[1] ? 4'b1100 : 4'b0011;
        wlanes_s = {2{cur_wdata_s[15:0]}};
      end
      2'b10: begin
        be_s     = 4'b1111;
        wlanes_s = cur_wdata_s;
      end
      default: begin
        be_s     = 4'b0000;
        wlanes_s = 32'h0000_0000;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= 32'h0000_0000;
      cap_f3_q    <= 3'b000;
      cap_wdata_q <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_f3_q    <= cap_f3_d;
      cap_wdata_q <= cap_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          ram_q[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.busRData = rdata_q;
  assign bus.busReady = ready_q;
  assign bus.busErr   = err_q;

endmodule
